// File: rtl/fir_pkg.sv
// Shared types and width helpers for the fir_chain transposed-form FIR.
package fir_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } fir_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator is wide enough to sum NTAPS full-precision products.
    function automatic int acc_width(input int dim_data, input int dim_coeff, input int ntaps);
        return dim_data + dim_coeff + clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_if.sv
// Sample, coefficient-load and result signals of fir_chain.
interface fir_if #(
    parameter int DIM_DATA  = 16,
    parameter int DIM_COEFF = 16,
    parameter int DIM_OUT   = 32
);
    logic                        clr;
    logic                        coeff_load;
    logic                        coeff_wr;
    logic signed [DIM_COEFF-1:0] coeff_in;
    // A sample transfers on a rising edge where in_valid && in_ready; data_in must be
    // stable while in_valid is high. There is no output backpressure: out_valid is a
    // one-cycle pulse and data_out/sat are meaningful only while it is high.
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DIM_DATA-1:0]  data_in;
    logic                        out_valid;
    logic signed [DIM_OUT-1:0]   data_out;
    logic                        sat;

    modport master (
        output clr, coeff_load, coeff_wr, coeff_in, in_valid, data_in,
        input  in_ready, out_valid, data_out, sat
    );

    modport slave (
        input  clr, coeff_load, coeff_wr, coeff_in, in_valid, data_in,
        output in_ready, out_valid, data_out, sat
    );
endinterface

// File: rtl/fir_tap.sv
// One transposed-form tap: coefficient register, product register and accumulator register.
module fir_tap #(
    parameter int DIM_DATA  = 16,
    parameter int DIM_COEFF = 16,
    parameter int DIM_ACC   = 35
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        accept_i,
    input  logic                        v1_i,
    input  logic                        flush_i,
    input  logic                        shift_i,
    input  logic signed [DIM_DATA-1:0]  data_i,
    input  logic signed [DIM_COEFF-1:0] coeff_i,
    input  logic signed [DIM_ACC-1:0]   acc_i,
    output logic signed [DIM_COEFF-1:0] coeff_o,
    output logic signed [DIM_ACC-1:0]   acc_o
);
    localparam int PW = DIM_DATA + DIM_COEFF;

    logic signed [DIM_COEFF-1:0] c_q;
    logic signed [PW-1:0]        p_q;
    logic signed [PW-1:0]        p_d;
    logic signed [DIM_ACC-1:0]   a_q;
    logic signed [DIM_ACC-1:0]   a_d;

    assign p_d = PW'(data_i) * PW'(c_q);
    assign a_d = DIM_ACC'(p_q) + acc_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       c_q <= '0;
        else if (shift_i) c_q <= coeff_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        p_q <= '0;
        else if (clr_i)    p_q <= '0;
        else if (accept_i) p_q <= p_d;
    end

    // A flush wipes history so products of old and new coefficients never mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  a_q <= '0;
        else if (clr_i || flush_i)   a_q <= '0;
        else if (v1_i)               a_q <= a_d;
    end

    assign coeff_o = c_q;
    assign acc_o   = a_q;
endmodule

// File: rtl/fir_chain.sv
// N-tap transposed-form FIR with serial coefficient load; FIR_SAT_EN selects
// saturating output reduction instead of two's-complement wrap.
module fir_chain
    import fir_pkg::*;
#(
    parameter int NTAPS     = 8,
    parameter int DIM_DATA  = 16,
    parameter int DIM_COEFF = 16,
    parameter int DIM_OUT   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    fir_if.slave       io,
    output fir_state_e dbg_state_o
);
    localparam int DIM_ACC = acc_width(DIM_DATA, DIM_COEFF, NTAPS);
    localparam int CW      = clog2(NTAPS);
    localparam logic [CW-1:0] LAST_WR = CW'(NTAPS - 1);

    fir_state_e              state_q;
    logic [CW-1:0]           cnt_q;
    logic                    in_ready_q;
    logic                    v1_q;
    logic                    v2_q;
    logic                    out_valid_q;
    logic signed [DIM_OUT-1:0] data_out_q;
    logic signed [DIM_OUT-1:0] data_out_d;
    logic                    sat_q;
    logic                    sat_d;
    logic                    accept;
    logic                    shift_en;
    logic                    load_done;

    logic signed [DIM_COEFF-1:0] coeff_chain [NTAPS+1];
    logic signed [DIM_ACC-1:0]   acc_chain   [NTAPS+1];

    assign accept    = io.in_valid && in_ready_q && !io.clr;
    // A coeff_load seen during LOAD restarts the count and suppresses a same-cycle write.
    assign shift_en  = (state_q == ST_LOAD) && io.coeff_wr && !io.coeff_load;
    assign load_done = shift_en && (cnt_q == LAST_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (io.coeff_load) begin
                        state_q    <= ST_LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (io.coeff_load) begin
                        cnt_q <= '0;
                    end else if (io.coeff_wr) begin
                        if (cnt_q == LAST_WR) begin
                            state_q    <= ST_RUN;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign coeff_chain[NTAPS] = io.coeff_in;
    assign acc_chain[NTAPS]   = '0;

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        fir_tap #(
            .DIM_DATA  (DIM_DATA),
            .DIM_COEFF (DIM_COEFF),
            .DIM_ACC   (DIM_ACC)
        ) u_tap (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (io.clr),
            .accept_i (accept),
            .v1_i     (v1_q),
            .flush_i  (load_done),
            .shift_i  (shift_en),
            .data_i   (io.data_in),
            .coeff_i  (coeff_chain[k+1]),
            .acc_i    (acc_chain[k+1]),
            .coeff_o  (coeff_chain[k]),
            .acc_o    (acc_chain[k])
        );
    end

    if (DIM_OUT >= DIM_ACC) begin : g_ext
        assign data_out_d = DIM_OUT'(acc_chain[0]);
        assign sat_d      = 1'b0;
    end else begin : g_narrow
`ifdef FIR_SAT_EN
        localparam logic signed [DIM_OUT-1:0] OUT_MAX = {1'b0, {(DIM_OUT-1){1'b1}}};
        localparam logic signed [DIM_OUT-1:0] OUT_MIN = {1'b1, {(DIM_OUT-1){1'b0}}};
        logic [DIM_ACC-DIM_OUT:0] top_bits;
        logic                     ovf;
        // In range only when the bits above the output sign bit all match it.
        assign top_bits   = acc_chain[0][DIM_ACC-1:DIM_OUT-1];
        assign ovf        = !((&top_bits) || !(|top_bits));
        assign data_out_d = ovf ? (top_bits[DIM_ACC-DIM_OUT] ? OUT_MIN : OUT_MAX)
                                : acc_chain[0][DIM_OUT-1:0];
        assign sat_d      = ovf;
`else
        assign data_out_d = acc_chain[0][DIM_OUT-1:0];
        assign sat_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else if (io.clr) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            v1_q        <= accept;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            sat_q       <= v2_q && sat_d;
            if (v2_q) data_out_q <= data_out_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.data_out  = data_out_q;
    assign io.sat       = sat_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_fir_chain.sv
// Self-checking bench for fir_chain (NTAPS=4, 16-bit output) against a sum-of-products model.
module tb_fir_chain;
  import fir_pkg::*;

  localparam int NT = 4;
  localparam int DD = 16;
  localparam int DC = 16;
  localparam int DO = 16;

  logic       clk;
  logic       rst_n;
  fir_state_e dbg_state;

  fir_if #(.DIM_DATA(DD), .DIM_COEFF(DC), .DIM_OUT(DO)) bus ();

  fir_chain #(.NTAPS(NT), .DIM_DATA(DD), .DIM_COEFF(DC), .DIM_OUT(DO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: y[n] = sum c[k]*x[n-k] over the samples accepted since the last flush
  longint      m_c [NT];
  longint      hist [$];
  longint      words [$];
  bit          m_load;
  int          cyc;
  logic [DO-1:0] exp_q [$];
  bit          exp_sat_q [$];
  int          exp_edge_q [$];

  function automatic logic [DO-1:0] reduce(input longint y, output bit s);
    longint mx;
    longint mn;
    logic [DO-1:0] r;
    mx = (longint'(1) << (DO - 1)) - 1;
    mn = -mx - 1;
    s  = 1'b0;
    r  = y[DO-1:0];
`ifdef FIR_SAT_EN
    if (y > mx) begin
      r = mx[DO-1:0];
      s = 1'b1;
    end else if (y < mn) begin
      r = mn[DO-1:0];
      s = 1'b1;
    end
`endif
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_c[k]) m_c[k] = 0;
      hist.delete();
      words.delete();
      exp_q.delete();
      exp_sat_q.delete();
      exp_edge_q.delete();
      m_load = 1'b0;
    end else begin
      longint y;
      bit s;
      cyc++;
      if (bus.clr) begin
        hist.delete();
        exp_q.delete();
        exp_sat_q.delete();
        exp_edge_q.delete();
      end else if (bus.in_valid && !m_load) begin
        hist.push_front(longint'(bus.data_in));
        if (hist.size() > NT) void'(hist.pop_back());
        y = 0;
        foreach (hist[k]) y += m_c[k] * hist[k];
        exp_q.push_back(reduce(y, s));
        exp_sat_q.push_back(s);
        exp_edge_q.push_back(cyc + 2);
      end
      if (!m_load) begin
        if (bus.coeff_load) begin
          m_load = 1'b1;
          words.delete();
        end
      end else if (bus.coeff_load) begin
        words.delete();
      end else if (bus.coeff_wr) begin
        words.push_back(longint'(bus.coeff_in));
        if (words.size() == NT) begin
          foreach (m_c[k]) m_c[k] = words[k];
          m_load = 1'b0;
          hist.delete();
        end
      end
    end
  end

  // scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.in_ready, !m_load);
      check("state", dbg_state, m_load);
      if (bus.out_valid) begin
        if (exp_edge_q.size() == 0) begin
          check("out_spurious", 1, 0);
        end else begin
          check("out_edge", cyc, exp_edge_q[0]);
          check("data_out", $unsigned(bus.data_out), exp_q[0]);
          check("sat", bus.sat, exp_sat_q[0]);
          void'(exp_q.pop_front());
          void'(exp_sat_q.pop_front());
          void'(exp_edge_q.pop_front());
        end
      end else if (exp_edge_q.size() != 0 && exp_edge_q[0] <= cyc) begin
        check("out_missing", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_sat_q.pop_front());
        void'(exp_edge_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit valid, input int x);
    bus.in_valid = valid;
    bus.data_in  = x[DD-1:0];
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load();
    bus.coeff_load = 1'b1;
    tick();
    bus.coeff_load = 1'b0;
  endtask

  task automatic write_coeff(input int v);
    bus.coeff_wr = 1'b1;
    bus.coeff_in = v[DC-1:0];
    tick();
    bus.coeff_wr = 1'b0;
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    pulse_load();
    write_coeff(c0);
    write_coeff(c1);
    write_coeff(c2);
    write_coeff(c3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_data_out"}, $unsigned(bus.data_out), 0);
    check({tag, "_sat"}, bus.sat, 0);
    check({tag, "_state"}, dbg_state, ST_RUN);
  endtask

  task automatic impulse();
    send(1, 1);
    for (int i = 0; i < 4; i++) send(1, 0);
    idle(3);
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  initial begin
    rst_n          = 1'b0;
    cyc            = 0;
    bus.clr        = 1'b0;
    bus.coeff_load = 1'b0;
    bus.coeff_wr   = 1'b0;
    bus.coeff_in   = '0;
    bus.in_valid   = 1'b0;
    bus.data_in    = '0;
    #12;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // impulse response 1,2,3,4,0
    load4(1, 2, 3, 4);
    impulse();

    // signed samples with a gap in valid
    load4(-1, -1, -1, -1);
    send(1, 100);
    idle(3);
    send(1, -50);
    idle(4);

    // overflow of the 16-bit output
    load4(32767, 32767, 32767, 32767);
    for (int i = 0; i < 4; i++) send(1, 32767);
    idle(4);

    // reload mid-stream, with a sample accepted in the coeff_load cycle
    load4(1, 2, 3, 4);
    send(1, 7);
    send(1, -3);
    bus.in_valid = 1'b1;
    bus.data_in  = 16'sd9;
    pulse_load();
    bus.in_valid = 1'b1;
    write_coeff(5);
    bus.in_valid = 1'b0;
    write_coeff(6);
    pulse_load();
    for (int i = 0; i < 4; i++) write_coeff(10 + i);
    send(1, 2);
    send(1, 1);
    idle(4);

    // clr coincident with a sample drops it; coefficients survive
    load4(1, 2, 3, 4);
    send(1, 11);
    send(1, 12);
    bus.clr = 1'b1;
    send(1, 13);
    bus.clr = 1'b0;
    idle(3);
    impulse();

    // reset in the middle of a load zeroes the coefficients
    pulse_load();
    write_coeff(3);
    write_coeff(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload");
    tick();
    rst_n = 1'b1;
    tick();
    impulse();

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      int cl;
      int dl;
      cl = (r % 2 == 0) ? 50 : 32767;
      dl = (r % 2 == 0) ? 150 : 32767;
      bus.in_valid = 1'b1;
      bus.data_in  = 16'(rnd(dl));
      pulse_load();
      for (int i = 0; i < NT; i++) write_coeff(rnd(cl));
      for (int i = 0; i < 60; i++) begin
        bus.clr = ($urandom_range(0, 24) == 0);
        send($urandom_range(0, 3) != 0, rnd(dl));
        bus.clr = 1'b0;
      end
      idle(3);
    end

    idle(4);
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
